// File: rtl/wb_pkg.sv
// Shared types for the Wishbone LED pattern master: pattern modes, FSM states
// and bounce direction.
package wb_pkg;

  localparam int BYTE = 8;

  typedef enum logic [1:0] {
    MODE_WALK   = 2'd0,
    MODE_COUNT  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

endpackage

// File: rtl/tick_gen.sv
// Free-running update-period counter; tick_o pulses on the last count of
// each PERIOD while enabled, and the count is parked at 0 while disabled.
module tick_gen #(
  parameter int PERIOD = 50000000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int            CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default assigned first so every path drives cnt_d; no latch.
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/wb_led_pattern_master.sv
// Wishbone classic master that writes a walking/counting/bouncing/held LED
// pattern to a downstream slave once per tick, flagging unacknowledged cycles.
module wb_led_pattern_master
  import wb_pkg::*;
#(
  parameter int WORD    = 16,
  parameter int LEDS    = WORD,
  parameter int PERIOD  = 50000000,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic [1:0]           mode_i,
  input  logic                 clr_err_i,
  input  logic                 ack_i,
  output logic                 cyc_o,
  output logic                 stb_o,
  output logic                 we_o,
  output logic [WORD/BYTE-1:0] sel_o,
  output logic [WORD-1:0]      dat_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int            TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef struct packed {
    logic [LEDS-1:0] pat;
    dir_e            dir;
  } step_t;

  function automatic step_t next_step(input logic [LEDS-1:0] pat,
                                      input dir_e dir, input mode_e mode);
    step_t           s;
    logic [LEDS-1:0] one;
    one   = LEDS'(1);
    s.pat = pat;
    s.dir = dir;
    case (mode)
      MODE_WALK:  s.pat = (pat == '0) ? one : ((pat << 1) | (pat >> (LEDS - 1)));
      MODE_COUNT: s.pat = pat + one;
      MODE_BOUNCE: begin
        if (LEDS == 1 || pat == '0) begin
          s.pat = one;
          s.dir = DIR_LEFT;
        end else if (dir == DIR_LEFT) begin
          s.pat = pat << 1;
          if (s.pat[LEDS-1]) s.dir = DIR_RIGHT;
        end else begin
          s.pat = pat >> 1;
          if (s.pat == one) s.dir = DIR_LEFT;
        end
      end
      default: s.pat = pat;
    endcase
    return s;
  endfunction

  state_e          state_q, state_d;
  logic [LEDS-1:0] pat_q, pat_d;
  dir_e            dir_q, dir_d, dir_pend_q, dir_pend_d;
  logic [WORD-1:0] dat_q, dat_d;
  logic [TW-1:0]   to_q, to_d;
  logic            err_q, err_d;
  logic            tick;
  logic            timeout;
  step_t           nxt;

  tick_gen #(.PERIOD(PERIOD)) u_tick_gen (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .en_i   (en_i),
    .tick_o (tick)
  );

  assign nxt = next_step(pat_q, dir_q, mode_e'(mode_i));

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    dir_d      = dir_q;
    dir_pend_d = dir_pend_q;
    dat_d      = dat_q;
    to_d       = to_q;
    timeout    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          dat_d      = WORD'(nxt.pat);
          dir_pend_d = nxt.dir;
          to_d       = '0;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Pattern and direction commit only on ack, so a timeout retries the same step.
        if (ack_i) begin
          pat_d   = dat_q[LEDS-1:0];
          dir_d   = dir_pend_q;
          state_d = ST_IDLE;
        end else if (to_q == TO_LAST) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Set wins over a coincident clear.
    err_d = timeout ? 1'b1 : (clr_err_i ? 1'b0 : err_q);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      pat_q      <= '0;
      dir_q      <= DIR_LEFT;
      dir_pend_q <= DIR_LEFT;
      dat_q      <= '0;
      to_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      dir_q      <= dir_d;
      dir_pend_q <= dir_pend_d;
      dat_q      <= dat_d;
      to_q       <= to_d;
      err_q      <= err_d;
    end
  end

  assign busy_o = (state_q == ST_WRITE);
  assign cyc_o  = busy_o;
  assign stb_o  = busy_o;
  assign we_o   = busy_o;
  assign sel_o  = busy_o ? '1 : '0;
  assign dat_o  = dat_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_wb_led_pattern_master.sv
// Scoreboard bench: stimulus queues expected writes, a negedge monitor pops and
// compares every acknowledged Wishbone write.
module tb_wb_led_pattern_master;

  localparam int WORD    = 16;
  localparam int LEDS    = 4;
  localparam int PERIOD  = 8;
  localparam int TIMEOUT = 4;

  logic              clk_i     = 1'b0;
  logic              rst_n_i   = 1'b0;
  logic              en_i      = 1'b0;
  logic [1:0]        mode_i    = 2'd0;
  logic              clr_err_i = 1'b0;
  logic              ack_i;
  logic              cyc_o, stb_o, we_o, busy_o, err_o;
  logic [WORD/8-1:0] sel_o;
  logic [WORD-1:0]   dat_o;

  logic slave_en  = 1'b1;
  int   ack_delay = 0;
  int   wait_cnt  = 0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WORD-1:0] dat;
    int              len;
  } exp_t;
  exp_t exp_q[$];

  initial forever #5 clk_i = ~clk_i;

  // Slave model: combinational ack, optionally held off for ack_delay cycles.
  assign ack_i = slave_en && cyc_o && stb_o && (wait_cnt >= ack_delay);
  always @(posedge clk_i) begin
    if (cyc_o && !ack_i) wait_cnt <= wait_cnt + 1;
    else                 wait_cnt <= 0;
  end

  wb_led_pattern_master #(
    .WORD(WORD), .LEDS(LEDS), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .en_i     (en_i),
    .mode_i   (mode_i),
    .clr_err_i(clr_err_i),
    .ack_i    (ack_i),
    .cyc_o    (cyc_o),
    .stb_o    (stb_o),
    .we_o     (we_o),
    .sel_o    (sel_o),
    .dat_o    (dat_o),
    .busy_o   (busy_o),
    .err_o    (err_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [WORD-1:0] dat, input int len);
    exp_t e;
    e.dat = dat;
    e.len = len;
    exp_q.push_back(e);
  endtask

  // Monitor: every acknowledged write must match the head of the queue.
  initial begin : monitor
    int   cyc_len;
    exp_t e;
    cyc_len = 0;
    forever begin
      @(negedge clk_i);
      if (cyc_o) cyc_len++;
      else       cyc_len = 0;
      if (cyc_o && stb_o && ack_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("wr_dat", dat_o, e.dat);
          check("wr_sel", sel_o, 2'b11);
          check("wr_we", we_o, 1);
          check("wr_cyc_len", cyc_len, e.len);
        end
        cyc_len = 0;
      end
    end
  end

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk_i);
      #2;
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_cyc_high(input int budget, input string name);
    int n = 0;
    while (!cyc_o && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check(name, cyc_o, 1);
  endtask

  task automatic measure_cyc(input int budget, output int len);
    len = 0;
    while (cyc_o && len < budget) begin
      len++;
      @(negedge clk_i);
    end
  endtask

  task automatic do_reset();
    en_i    = 1'b0;
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [WORD-1:0] bounce_seq [8];
    int len;
    int hi;
    bounce_seq = '{16'h1, 16'h2, 16'h4, 16'h8, 16'h4, 16'h2, 16'h1, 16'h2};

    // Reset state
    #22;
    check("rst_cyc", cyc_o, 0);
    check("rst_stb", stb_o, 0);
    check("rst_we", we_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    check("rst_sel", sel_o, 0);
    check("rst_dat", dat_o, 0);
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;

    // 1: WALK from reset
    mode_i = 2'd0;
    push(16'h0001, 1); push(16'h0002, 1); push(16'h0004, 1);
    push(16'h0008, 1); push(16'h0001, 1);
    en_i = 1'b1;
    wait_drain(100, "t1_walk_drain");
    en_i = 1'b0;

    // 2: COUNT through 0xE, 0xF and wrap to 0
    do_reset();
    mode_i = 2'd1;
    for (int i = 1; i < 16; i++) push(WORD'(i), 1);
    push(16'h0000, 1);
    en_i = 1'b1;
    wait_drain(200, "t2_count_drain");
    en_i = 1'b0;

    // 3: BOUNCE from reset
    do_reset();
    mode_i = 2'd2;
    for (int i = 0; i < 8; i++) push(bounce_seq[i], 1);
    en_i = 1'b1;
    wait_drain(120, "t3_bounce_drain");
    en_i = 1'b0;

    // 4: timeout, retry, sticky error and clear
    do_reset();
    mode_i   = 2'd0;
    slave_en = 1'b0;
    en_i     = 1'b1;
    wait_cyc_high(40, "t4_cyc_start");
    measure_cyc(40, len);
    check("t4_timeout_len", len, TIMEOUT);
    check("t4_err_set", err_o, 1);
    slave_en = 1'b1;
    push(16'h0001, 1);
    wait_drain(40, "t4_retry_drain");
    en_i = 1'b0;
    check("t4_err_sticky", err_o, 1);
    @(posedge clk_i);
    #1 clr_err_i = 1'b1;
    @(posedge clk_i);
    #1 clr_err_i = 1'b0;
    check("t4_err_clr", err_o, 0);

    // 5a: delayed ack with en_i dropped mid-WRITE
    do_reset();
    mode_i    = 2'd0;
    ack_delay = 2;
    push(16'h0001, 3);
    en_i = 1'b1;
    wait_cyc_high(40, "t5_cyc_start");
    en_i = 1'b0;
    wait_drain(20, "t5_delayed_drain");
    hi = 0;
    repeat (30) begin
      @(negedge clk_i);
      if (cyc_o) hi++;
    end
    check("t5_no_more_writes", hi, 0);
    ack_delay = 0;
    push(16'h0002, 1);
    en_i = 1'b1;
    wait_drain(40, "t5_pat_committed");
    en_i = 1'b0;

    // 5b: async reset mid-WRITE
    slave_en = 1'b0;
    en_i     = 1'b1;
    wait_cyc_high(40, "t5_cyc_start2");
    #2 rst_n_i = 1'b0;
    #1;
    check("t5_rst_cyc", cyc_o, 0);
    check("t5_rst_stb", stb_o, 0);
    check("t5_rst_busy", busy_o, 0);
    en_i     = 1'b0;
    slave_en = 1'b1;
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    push(16'h0001, 1);
    en_i = 1'b1;
    wait_drain(40, "t5_after_rst");
    en_i = 1'b0;

    // 6: HOLD refresh, then back to WALK
    do_reset();
    mode_i = 2'd0;
    push(16'h0001, 1); push(16'h0002, 1); push(16'h0004, 1);
    en_i = 1'b1;
    wait_drain(60, "t6_walk_drain");
    en_i   = 1'b0;
    mode_i = 2'd3;
    push(16'h0004, 1); push(16'h0004, 1); push(16'h0004, 1);
    en_i = 1'b1;
    wait_drain(60, "t6_hold_drain");
    en_i   = 1'b0;
    mode_i = 2'd0;
    push(16'h0008, 1);
    en_i = 1'b1;
    wait_drain(40, "t6_walk_resume");
    en_i = 1'b0;

    repeat (20) @(negedge clk_i);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_led_pattern_master.md
Name: wb_led_pattern_master

Overview:
- Wishbone classic master that periodically writes an LED pattern word to an LED output slave on the same bus segment.
- Sits directly upstream of the LED slave; the slave acks combinationally (ack = stb & cyc) and latches on the falling clock edge.
- Generates walking, counting, bouncing or hold patterns at a programmable update period.
- Flags slaves that do not acknowledge within a timeout.

Parameters:
- WORD, 16, bus data width in bits; multiple of 8.
- LEDS, WORD, number of pattern bits; must be <= WORD.
- PERIOD, 50000000, clock cycles between pattern updates; must be > TIMEOUT+2.
- TIMEOUT, 16, maximum cycles in WRITE without ack before abort; must be >= 1.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- en_i  in  1  pattern generation enable.
- mode_i  in  2  0 WALK, 1 COUNT, 2 BOUNCE, 3 HOLD.
- clr_err_i  in  1  synchronous clear of err_o.
- ack_i  in  1  Wishbone acknowledge from slave.
- cyc_o  out  1  Wishbone cycle.
- stb_o  out  1  Wishbone strobe.
- we_o  out  1  Wishbone write enable; always 1 during a cycle.
- sel_o  out  WORD/8  byte selects; all ones during a cycle.
- dat_o  out  WORD  write data; pattern zero-extended from LEDS to WORD.
- busy_o  out  1  high while in WRITE.
- err_o  out  1  sticky timeout flag.

Behaviour:
- Reset (async, rst_n_i=0):
  - cyc_o, stb_o, we_o, busy_o and err_o are 0; sel_o and dat_o are 0.
  - Committed pattern pat_q is 0; bounce direction is left; FSM is IDLE; tick and timeout counters are 0.
- Tick generator:
  - While en_i=1, counts 0..PERIOD-1 and pulses tick for one cycle when the count is PERIOD-1, then wraps to 0.
  - While en_i=0, the count is held at 0.
- FSM, two states:
  - IDLE: outputs are deasserted. On tick, compute nxt from pat_q and mode_i (sampled this cycle), register dat_o=nxt, and go to WRITE. cyc/stb/we/sel are asserted from the next cycle.
  - WRITE: cyc_o=stb_o=we_o=busy_o=1, sel_o all ones, dat_o stable.
  - In WRITE, ack_i=1 at a rising edge: pat_q<=dat_o[LEDS-1:0], bounce direction updated, go to IDLE. The bus cycle is exactly one cycle long when the slave acks combinationally.
  - In WRITE, no ack for TIMEOUT consecutive cycles: go to IDLE, set err_o, leave pat_q unchanged. The same nxt is recomputed on the next tick (retry).
- Pattern rules (width LEDS, all modulo 2^LEDS):
  - WALK: rotate pat_q left by 1; if pat_q==0, nxt=1.
  - COUNT: nxt=pat_q+1, wrapping to 0 after all ones.
  - BOUNCE:
    - If pat_q==0, nxt=1 and direction is left.
    - Moving left: shift left; when the result has its MSB set, direction becomes right.
    - Moving right: shift right; when the result equals 1, direction becomes left.
    - LEDS=1 degenerates to a constant 1.
  - HOLD: nxt=pat_q (periodic refresh write).
- Boundary conditions:
  - en_i falling during WRITE does not abandon the cycle. The transaction completes or times out; no new ticks follow.
  - mode_i changes take effect only at the next tick; bounce direction is retained across mode changes.
  - A tick arriving while in WRITE is ignored, which cannot occur under the PERIOD constraint.
  - clr_err_i and a timeout in the same cycle: err_o=1 (set wins).
  - Reset asserted mid-WRITE drops cyc/stb immediately (async) and discards the in-flight pattern.
  - ack_i while in IDLE is ignored.

Decomposition:
- Package wb_pkg holds:
  - typedef enum for pattern mode (WALK, COUNT, BOUNCE, HOLD), 2 bits;
  - typedef enum for FSM state (IDLE, WRITE);
  - localparam BYTE=8.
- Sub-module tick_gen: parameter PERIOD; ports clk_i, rst_n_i, en_i, tick_o.
- Pattern next-state logic stays in the top as a combinational function.

Test Plan (WORD=16, LEDS=4, PERIOD=8, TIMEOUT=4, slave model acks when stb&cyc unless stated):
1. Reset then en_i=1, WALK: writes of dat_o 0x0001, 0x0002, 0x0004, 0x0008, 0x0001 every 8 cycles. Each has cyc_o high for exactly 1 cycle and sel_o=2'b11.
2. COUNT from pat_q=0xE: writes 0xF then 0x0 (wrap); upper dat_o bits [15:4] are always 0.
3. BOUNCE from reset: sequence 1, 2, 4, 8, 4, 2, 1, 2.
4. Slave acks disabled, WALK: cyc_o high for 4 cycles, then drops with err_o=1. The next tick retries 0x0001. Re-enable ack and the write succeeds; err_o stays 1 until clr_err_i pulses, then reads 0.
5. Slave ack delayed 2 cycles; drop en_i and pull rst_n_i low mid-WRITE:
   - delayed ack: write still completes, pat_q updates, no further writes;
   - reset mid-WRITE: cyc_o/stb_o go 0 without waiting for a clock edge and pat_q returns to 0.
6. HOLD after WALK reached 0x4: repeated writes of 0x0004 every 8 cycles. Switching to WALK gives 0x0008 at the next tick.
